// File: rtl/clock_time_controller.sv
// 12-hour HH:MM:SS clock controller: one-second prescaler, time registers with AM/PM,
// and a two-button set-time mode with a blink phase for the display.
module clock_time_controller #(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [3:0] hours,
    output logic       pm,
    output logic [1:0] mode,
    output logic       blink,
    output logic       sec_tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_e;

    mode_e         mode_q, mode_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [3:0]    hr_q, hr_d;
    logic          pm_q, pm_d;
    logic          blink_q, blink_d;
    logic          btn_mode_q, btn_inc_q;

    logic          mode_press, inc_press, pre_wrap, tick;
    logic [3:0]    hr_adv;
    logic          pm_adv;

    assign mode_press = btn_mode & ~btn_mode_q;
    assign inc_press  = btn_inc & ~btn_inc_q;
    assign pre_wrap   = (pre_q == PRE_LAST);
    assign tick       = (mode_q == RUN) & pre_wrap;

    // Shared hour step used by both the running carry and the SET_HR button.
    always_comb begin
        hr_adv = hr_q + 4'd1;
        pm_adv = pm_q;
        if (hr_q == 4'd11) begin
            pm_adv = ~pm_q;
        end else if (hr_q == 4'd12) begin
            hr_adv = 4'd1;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        pm_d    = pm_q;
        blink_d = blink_q;
        pre_d   = pre_wrap ? '0 : pre_q + 1'b1;

        if (tick) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d = 6'd0;
                    hr_d  = hr_adv;
                    pm_d  = pm_adv;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        // A mode press always wins over a same-cycle increment press.
        case (mode_q)
            RUN: begin
                if (mode_press) mode_d = SET_HR;
            end
            SET_HR: begin
                if (mode_press) begin
                    mode_d = SET_MIN;
                end else if (inc_press) begin
                    hr_d = hr_adv;
                    pm_d = pm_adv;
                end
            end
            SET_MIN: begin
                if (mode_press) begin
                    mode_d = RUN;
                    sec_d  = 6'd0;
                end else if (inc_press) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
            end
            default: mode_d = RUN;
        endcase

        // Restarting the prescaler on a transition gives a full period before the next wrap.
        if (mode_press) begin
            pre_d   = '0;
            blink_d = 1'b0;
        end else if (mode_q == RUN) begin
            blink_d = 1'b0;
        end else if (pre_wrap) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= RUN;
            pre_q      <= '0;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hr_q       <= 4'd12;
            pm_q       <= 1'b0;
            blink_q    <= 1'b0;
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            pre_q      <= pre_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            pm_q       <= pm_d;
            blink_q    <= blink_d;
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
        end
    end

    assign seconds  = sec_q;
    assign minutes  = min_q;
    assign hours    = hr_q;
    assign pm       = pm_q;
    assign mode     = mode_q;
    assign blink    = blink_q;
    assign sec_tick = tick;

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller with TICK_DIV=4; expected values are hand-computed.
module tb_clock_time_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] seconds, minutes;
    logic [3:0] hours;
    logic       pm, blink, sec_tick;
    logic [1:0] mode;

    int n_cmp = 0;
    int n_err = 0;
    int ticks;

    clock_time_controller #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .seconds(seconds), .minutes(minutes), .hours(hours), .pm(pm),
        .mode(mode), .blink(blink), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s, input int p);
        chk({tag, ".hours"}, 32'(hours), 32'(h));
        chk({tag, ".minutes"}, 32'(minutes), 32'(m));
        chk({tag, ".seconds"}, 32'(seconds), 32'(s));
        chk({tag, ".pm"}, 32'(pm), 32'(p));
    endtask

    // Advance n rising edges, sampling 1 time unit after each; counts sec_tick highs seen.
    task automatic step(input int n, output int nt);
        nt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sec_tick) nt++;
        end
    endtask

    task automatic press_mode();
        int d;
        btn_mode = 1'b1;
        step(1, d);
        btn_mode = 1'b0;
        step(1, d);
    endtask

    task automatic press_inc(input int n);
        int d;
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1;
            step(1, d);
            btn_inc = 1'b0;
            step(1, d);
        end
    endtask

    initial begin
        step(3, ticks);
        chk_time("rst", 12, 0, 0, 0);
        chk("rst.mode", 32'(mode), 0);
        chk("rst.blink", 32'(blink), 0);
        chk("rst.tick", 32'(sec_tick), 0);
        reset = 1'b0;

        // First tick is high during the 4th cycle after release.
        step(2, ticks);
        chk("first.notick", 32'(ticks), 0);
        step(1, ticks);
        chk("first.tick", 32'(sec_tick), 1);
        chk("first.sec0", 32'(seconds), 0);
        step(1, ticks);
        chk("first.sec1", 32'(seconds), 1);
        chk("first.tickoff", 32'(sec_tick), 0);

        // 3599 more ticks -> 3600 total -> 1:00:00 AM.
        step(3599 * 4, ticks);
        chk("run1h.ticks", 32'(ticks), 3599);
        chk_time("run1h", 1, 0, 0, 0);

        // Enter SET_HR: no ticks, blink toggles on every 4th cycle.
        btn_mode = 1'b1;
        step(1, ticks);
        chk("sethr.mode", 32'(mode), 1);
        chk("sethr.blink0", 32'(blink), 0);
        btn_mode = 1'b0;
        step(3, ticks);
        chk("sethr.notick", 32'(ticks), 0);
        chk("sethr.blink_pre", 32'(blink), 0);
        step(1, ticks);
        chk("sethr.blink1", 32'(blink), 1);
        step(4, ticks);
        chk("sethr.blink2", 32'(blink), 0);
        chk("sethr.notick2", 32'(ticks), 0);

        // Hour increments from 1 AM: 11 presses -> 12 PM, 12th -> 1 PM.
        press_inc(11);
        chk_time("inc11", 12, 0, 0, 1);
        press_inc(1);
        chk_time("inc12", 1, 0, 0, 1);

        // Held increment button counts once.
        btn_inc = 1'b1;
        step(10, ticks);
        btn_inc = 1'b0;
        step(1, ticks);
        chk_time("hold", 2, 0, 0, 1);

        // 2 PM + 21 -> 11 AM (pm toggles at 11 PM -> 12 AM).
        press_inc(21);
        chk_time("to11am", 11, 0, 0, 0);

        // Simultaneous mode and inc: mode wins, hours unchanged.
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step(1, ticks);
        chk("simul.mode", 32'(mode), 2);
        chk("simul.hours", 32'(hours), 11);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(1, ticks);

        // Minutes wrap with no carry into hours.
        press_inc(58);
        chk("min58", 32'(minutes), 58);
        press_inc(3);
        chk_time("minwrap", 11, 1, 0, 0);
        press_inc(58);
        chk("min59", 32'(minutes), 59);

        // Back to RUN: seconds cleared, blink low, tick 4 cycles later.
        btn_mode = 1'b1;
        step(1, ticks);
        chk("torun.mode", 32'(mode), 0);
        chk("torun.blink", 32'(blink), 0);
        chk_time("torun", 11, 59, 0, 0);
        btn_mode = 1'b0;
        step(2, ticks);
        chk("torun.notick", 32'(ticks), 0);
        step(1, ticks);
        chk("torun.tick", 32'(sec_tick), 1);
        step(1, ticks);
        chk("torun.sec1", 32'(seconds), 1);

        // 11:59:59 AM -> 12:00:00 PM.
        step(58 * 4, ticks);
        chk_time("am_end", 11, 59, 59, 0);
        step(4, ticks);
        chk_time("noon", 12, 0, 0, 1);

        // 12:59:59 PM -> 1:00:00 PM.
        step(3599 * 4, ticks);
        chk_time("pm1259", 12, 59, 59, 1);
        step(4, ticks);
        chk_time("pm0100", 1, 0, 0, 1);

        // Build 7:42:13 PM in SET_MIN; seconds freeze in set modes.
        step(13 * 4, ticks);
        chk("sec13", 32'(seconds), 13);
        press_mode();
        chk("frz.mode", 32'(mode), 1);
        step(20, ticks);
        chk("frz.sec", 32'(seconds), 13);
        press_inc(6);
        press_mode();
        press_inc(42);
        chk_time("preset", 7, 42, 13, 1);
        chk("preset.mode", 32'(mode), 2);

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        chk_time("arst", 12, 0, 0, 0);
        chk("arst.mode", 32'(mode), 0);
        chk("arst.blink", 32'(blink), 0);
        chk("arst.tick", 32'(sec_tick), 0);
        step(2, ticks);
        reset = 1'b0;
        step(2, ticks);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
